// File: rtl/axi_rd_arbiter.sv
// Two-requester AXI read arbiter (icache=m0, dcache=m1) sharing one AR/R port, one burst in flight.
// Define AXI_ARB_RR_EN for round-robin on simultaneous requests; default build is fixed priority (m0 wins).
module axi_rd_arbiter #(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [ID_WIDTH-1:0]   m0_axi_arid,
    input  logic [ADDR_WIDTH-1:0] m0_axi_araddr,
    input  logic [7:0]            m0_axi_arlen,
    input  logic [2:0]            m0_axi_arsize,
    input  logic [1:0]            m0_axi_arburst,
    input  logic                  m0_axi_arlock,
    input  logic [3:0]            m0_axi_arcache,
    input  logic [2:0]            m0_axi_arprot,
    input  logic                  m0_axi_arvalid,
    output logic                  m0_axi_arready,
    output logic [ID_WIDTH-1:0]   m0_axi_rid,
    output logic [DATA_WIDTH-1:0] m0_axi_rdata,
    output logic [1:0]            m0_axi_rresp,
    output logic                  m0_axi_rlast,
    output logic                  m0_axi_rvalid,
    input  logic                  m0_axi_rready,

    input  logic [ID_WIDTH-1:0]   m1_axi_arid,
    input  logic [ADDR_WIDTH-1:0] m1_axi_araddr,
    input  logic [7:0]            m1_axi_arlen,
    input  logic [2:0]            m1_axi_arsize,
    input  logic [1:0]            m1_axi_arburst,
    input  logic                  m1_axi_arlock,
    input  logic [3:0]            m1_axi_arcache,
    input  logic [2:0]            m1_axi_arprot,
    input  logic                  m1_axi_arvalid,
    output logic                  m1_axi_arready,
    output logic [ID_WIDTH-1:0]   m1_axi_rid,
    output logic [DATA_WIDTH-1:0] m1_axi_rdata,
    output logic [1:0]            m1_axi_rresp,
    output logic                  m1_axi_rlast,
    output logic                  m1_axi_rvalid,
    input  logic                  m1_axi_rready,

    output logic [ID_WIDTH-1:0]   s_axi_arid,
    output logic [ADDR_WIDTH-1:0] s_axi_araddr,
    output logic [7:0]            s_axi_arlen,
    output logic [2:0]            s_axi_arsize,
    output logic [1:0]            s_axi_arburst,
    output logic                  s_axi_arlock,
    output logic [3:0]            s_axi_arcache,
    output logic [2:0]            s_axi_arprot,
    output logic                  s_axi_arvalid,
    input  logic                  s_axi_arready,
    input  logic [ID_WIDTH-1:0]   s_axi_rid,
    input  logic [DATA_WIDTH-1:0] s_axi_rdata,
    input  logic [1:0]            s_axi_rresp,
    input  logic                  s_axi_rlast,
    input  logic                  s_axi_rvalid,
    output logic                  s_axi_rready,

    output logic                  grant,
    output logic [1:0]            state_o
);

    // Handshakes: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   grant_q, grant_d;
    logic   last_served_q, last_served_d;
    logic   pick;
    logic   sel_arvalid;
    logic   sel_rready;

    assign sel_arvalid = grant_q ? m1_axi_arvalid : m0_axi_arvalid;
    assign sel_rready  = grant_q ? m1_axi_rready  : m0_axi_rready;

`ifdef AXI_ARB_RR_EN
    // On a tie, the requester that was not served last goes next.
    assign pick = m0_axi_arvalid ? (m1_axi_arvalid ? ~last_served_q : 1'b0) : 1'b1;
`else
    assign pick = ~m0_axi_arvalid;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            grant_q       <= 1'b0;
            last_served_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_served_q <= last_served_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_served_d = last_served_q;
        case (state_q)
            IDLE: begin
                if (m0_axi_arvalid || m1_axi_arvalid) begin
                    state_d = ADDR;
                    grant_d = pick;
                end
            end
            ADDR: begin
                if (sel_arvalid && s_axi_arready) state_d = DATA;
            end
            DATA: begin
                if (s_axi_rvalid && sel_rready && s_axi_rlast) begin
                    state_d       = IDLE;
                    last_served_d = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_axi_arid     = '0;
        s_axi_araddr   = '0;
        s_axi_arlen    = '0;
        s_axi_arsize   = '0;
        s_axi_arburst  = '0;
        s_axi_arlock   = 1'b0;
        s_axi_arcache  = '0;
        s_axi_arprot   = '0;
        s_axi_arvalid  = 1'b0;
        s_axi_rready   = 1'b0;
        m0_axi_arready = 1'b0;
        m1_axi_arready = 1'b0;
        m0_axi_rid     = '0;
        m0_axi_rdata   = '0;
        m0_axi_rresp   = '0;
        m0_axi_rlast   = 1'b0;
        m0_axi_rvalid  = 1'b0;
        m1_axi_rid     = '0;
        m1_axi_rdata   = '0;
        m1_axi_rresp   = '0;
        m1_axi_rlast   = 1'b0;
        m1_axi_rvalid  = 1'b0;
        case (state_q)
            ADDR: begin
                s_axi_arid     = grant_q ? m1_axi_arid    : m0_axi_arid;
                s_axi_araddr   = grant_q ? m1_axi_araddr  : m0_axi_araddr;
                s_axi_arlen    = grant_q ? m1_axi_arlen   : m0_axi_arlen;
                s_axi_arsize   = grant_q ? m1_axi_arsize  : m0_axi_arsize;
                s_axi_arburst  = grant_q ? m1_axi_arburst : m0_axi_arburst;
                s_axi_arlock   = grant_q ? m1_axi_arlock  : m0_axi_arlock;
                s_axi_arcache  = grant_q ? m1_axi_arcache : m0_axi_arcache;
                s_axi_arprot   = grant_q ? m1_axi_arprot  : m0_axi_arprot;
                s_axi_arvalid  = sel_arvalid;
                m0_axi_arready = ~grant_q & s_axi_arready;
                m1_axi_arready = grant_q & s_axi_arready;
            end
            DATA: begin
                s_axi_rready = sel_rready;
                if (grant_q) begin
                    m1_axi_rid    = s_axi_rid;
                    m1_axi_rdata  = s_axi_rdata;
                    m1_axi_rresp  = s_axi_rresp;
                    m1_axi_rlast  = s_axi_rlast;
                    m1_axi_rvalid = s_axi_rvalid;
                end else begin
                    m0_axi_rid    = s_axi_rid;
                    m0_axi_rdata  = s_axi_rdata;
                    m0_axi_rresp  = s_axi_rresp;
                    m0_axi_rlast  = s_axi_rlast;
                    m0_axi_rvalid = s_axi_rvalid;
                end
            end
            default: ;
        endcase
    end

    assign grant   = grant_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: single bursts, AR stalls, hold-off, tie arbitration, reset mid-burst.
module tb_axi_rd_arbiter;
    localparam int IW = 13;
    localparam int AW = 64;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic [IW-1:0] m0_arid, m1_arid, s_arid, m0_rid, m1_rid, s_rid;
    logic [AW-1:0] m0_araddr, m1_araddr, s_araddr;
    logic [7:0]    m0_arlen, m1_arlen, s_arlen;
    logic [2:0]    m0_arsize, m1_arsize, s_arsize, m0_arprot, m1_arprot, s_arprot;
    logic [1:0]    m0_arburst, m1_arburst, s_arburst, m0_rresp, m1_rresp, s_rresp;
    logic          m0_arlock, m1_arlock, s_arlock;
    logic [3:0]    m0_arcache, m1_arcache, s_arcache;
    logic          m0_arvalid, m1_arvalid, s_arvalid, m0_arready, m1_arready, s_arready;
    logic [DW-1:0] m0_rdata, m1_rdata, s_rdata;
    logic          m0_rlast, m1_rlast, s_rlast, m0_rvalid, m1_rvalid, s_rvalid;
    logic          m0_rready, m1_rready, s_rready;
    logic          grant;
    logic [1:0]    state;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    axi_rd_arbiter #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .m0_axi_arid(m0_arid), .m0_axi_araddr(m0_araddr), .m0_axi_arlen(m0_arlen),
        .m0_axi_arsize(m0_arsize), .m0_axi_arburst(m0_arburst), .m0_axi_arlock(m0_arlock),
        .m0_axi_arcache(m0_arcache), .m0_axi_arprot(m0_arprot), .m0_axi_arvalid(m0_arvalid),
        .m0_axi_arready(m0_arready), .m0_axi_rid(m0_rid), .m0_axi_rdata(m0_rdata),
        .m0_axi_rresp(m0_rresp), .m0_axi_rlast(m0_rlast), .m0_axi_rvalid(m0_rvalid),
        .m0_axi_rready(m0_rready),
        .m1_axi_arid(m1_arid), .m1_axi_araddr(m1_araddr), .m1_axi_arlen(m1_arlen),
        .m1_axi_arsize(m1_arsize), .m1_axi_arburst(m1_arburst), .m1_axi_arlock(m1_arlock),
        .m1_axi_arcache(m1_arcache), .m1_axi_arprot(m1_arprot), .m1_axi_arvalid(m1_arvalid),
        .m1_axi_arready(m1_arready), .m1_axi_rid(m1_rid), .m1_axi_rdata(m1_rdata),
        .m1_axi_rresp(m1_rresp), .m1_axi_rlast(m1_rlast), .m1_axi_rvalid(m1_rvalid),
        .m1_axi_rready(m1_rready),
        .s_axi_arid(s_arid), .s_axi_araddr(s_araddr), .s_axi_arlen(s_arlen),
        .s_axi_arsize(s_arsize), .s_axi_arburst(s_arburst), .s_axi_arlock(s_arlock),
        .s_axi_arcache(s_arcache), .s_axi_arprot(s_arprot), .s_axi_arvalid(s_arvalid),
        .s_axi_arready(s_arready), .s_axi_rid(s_rid), .s_axi_rdata(s_rdata),
        .s_axi_rresp(s_rresp), .s_axi_rlast(s_rlast), .s_axi_rvalid(s_rvalid),
        .s_axi_rready(s_rready),
        .grant(grant), .state_o(state)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One R beat from the slave to requester m; the other requester's rready is held low.
    task automatic beat(input int m, input logic [63:0] data, input logic last);
        s_rvalid  = 1'b1;
        s_rdata   = data;
        s_rlast   = last;
        s_rid     = 13'h0a5;
        m0_rready = (m == 0);
        m1_rready = (m == 1);
        #1;
        check("beat_rvalid", (m == 0) ? m0_rvalid : m1_rvalid, 1'b1);
        check("beat_rdata",  (m == 0) ? m0_rdata  : m1_rdata,  data);
        check("beat_other",  (m == 0) ? m1_rvalid : m0_rvalid, 1'b0);
        check("beat_srready", s_rready, 1'b1);
        tick();
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
    endtask

    initial begin
        m0_arid = 13'h005; m0_araddr = '0; m0_arlen = 8'd0; m0_arsize = 3'd3; m0_arburst = 2'd1;
        m0_arlock = 1'b0; m0_arcache = 4'h3; m0_arprot = 3'd0; m0_arvalid = 1'b0; m0_rready = 1'b0;
        m1_arid = 13'h1f0; m1_araddr = '0; m1_arlen = 8'd0; m1_arsize = 3'd3; m1_arburst = 2'd1;
        m1_arlock = 1'b0; m1_arcache = 4'h3; m1_arprot = 3'd2; m1_arvalid = 1'b0; m1_rready = 1'b0;
        s_arready = 1'b0; s_rid = '0; s_rdata = '0; s_rresp = 2'd0; s_rlast = 1'b0; s_rvalid = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_state", state, 2'd0);
        check("rst_grant", grant, 1'b0);
        check("rst_sarvalid", s_arvalid, 1'b0);
        check("rst_srready", s_rready, 1'b0);
        check("rst_arready", {m0_arready, m1_arready}, 2'b00);
        reset = 1'b0;
        tick();

        // Stray R beat while idle is not forwarded
        s_rvalid = 1'b1;
        #1;
        check("idle_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
        s_rvalid = 1'b0;

        // m0 alone: 8-beat burst at 0x1000
        m0_araddr = 64'h1000; m0_arlen = 8'd7; m0_arvalid = 1'b1; s_arready = 1'b1;
        #1;
        check("m0_idle_sarvalid", s_arvalid, 1'b0);
        tick();
        check("m0_addr_state", state, 2'd1);
        check("m0_sarvalid", s_arvalid, 1'b1);
        check("m0_saraddr", s_araddr, 64'h1000);
        check("m0_sarlen", s_arlen, 8'd7);
        check("m0_sarid", s_arid, 13'h005);
        check("m0_arready", {m0_arready, m1_arready}, 2'b10);
        tick();
        m0_arvalid = 1'b0; s_arready = 1'b0;
        check("m0_data_state", state, 2'd2);
        for (int i = 0; i < 8; i++) beat(0, 64'hA0 + 64'(i), i == 7);
        check("m0_done_state", state, 2'd0);

        // m1 alone with the slave stalling AR for 5 cycles, then m1 dropping arvalid
        m1_araddr = 64'h3000; m1_arlen = 8'd1; m1_arvalid = 1'b1;
        tick();
        check("stall_grant", grant, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("stall_sarvalid", s_arvalid, 1'b1);
            check("stall_saraddr", s_araddr, 64'h3000);
            check("stall_state", state, 2'd1);
            check("stall_arready", m1_arready, 1'b0);
            tick();
        end
        m1_arvalid = 1'b0;
        #1;
        check("drop_sarvalid", s_arvalid, 1'b0);
        tick();
        check("drop_state", state, 2'd1);
        check("drop_grant", grant, 1'b1);
        m1_arvalid = 1'b1; s_arready = 1'b1;
        #1;
        check("m1_arready", {m0_arready, m1_arready}, 2'b01);
        tick();
        m1_arvalid = 1'b0; s_arready = 1'b0;
        check("m1_data_state", state, 2'd2);
        beat(1, 64'hB0, 1'b0);
        beat(1, 64'hB1, 1'b1);
        check("m1_done_state", state, 2'd0);

        // m1 arrives during m0 DATA beat 3: held off, then AR issued two edges after rlast
        m0_araddr = 64'h1800; m0_arlen = 8'd7; m0_arvalid = 1'b1; s_arready = 1'b1;
        tick(); tick();
        m0_arvalid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                m1_araddr = 64'h2000; m1_arvalid = 1'b1;
            end
            #1;
            check("hold_m1_arready", m1_arready, 1'b0);
            beat(0, 64'hC0 + 64'(i), i == 7);
        end
        check("hold_idle_state", state, 2'd0);
        check("hold_idle_arready", m1_arready, 1'b0);
        tick();
        check("hold_addr_state", state, 2'd1);
        check("hold_grant", grant, 1'b1);
        check("hold_saraddr", s_araddr, 64'h2000);
        check("hold_arready", m1_arready, 1'b1);
        tick();
        check("hold_data_state", state, 2'd2);
        m1_arvalid = 1'b0;
        beat(1, 64'hD0, 1'b1);

        // Simultaneous requests held continuously from a fresh reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m0_arvalid = 1'b1; m1_arvalid = 1'b1; s_arready = 1'b1;
        for (int r = 0; r < 4; r++) begin
`ifdef AXI_ARB_RR_EN
            logic exp_g;
            exp_g = r[0];
`else
            logic exp_g;
            exp_g = 1'b0;
`endif
            tick();
            check("tie_state", state, 2'd1);
            check("tie_grant", grant, exp_g);
            tick();
            check("tie_data", state, 2'd2);
            beat(exp_g ? 1 : 0, 64'hE0 + 64'(r), 1'b1);
        end
        m0_arvalid = 1'b0; m1_arvalid = 1'b0;

        // Reset at beat 4 of an m1 burst
        m1_araddr = 64'h4000; m1_arlen = 8'd7; m1_arvalid = 1'b1;
        tick(); tick();
        m1_arvalid = 1'b0;
        check("rb_grant", grant, 1'b1);
        for (int i = 0; i < 4; i++) beat(1, 64'hF0 + 64'(i), 1'b0);
        s_rvalid = 1'b1; s_rdata = 64'hF4; m1_rready = 1'b1;
        #1;
        check("rb_pre_rvalid", m1_rvalid, 1'b1);
        reset = 1'b1;
        #1;
        check("rb_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
        check("rb_srready", s_rready, 1'b0);
        check("rb_state", state, 2'd0);
        check("rb_grant0", grant, 1'b0);
        tick();
        reset = 1'b0;
        s_rdata = 64'hF5;
        tick();
        check("rb_after_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
        check("rb_after_state", state, 2'd0);
        s_rvalid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
